// File: rtl/frv_dmem_arbiter_if.sv
// Data-memory bus bundle: req/gnt request channel plus in-order recv/ack response channel.
// The master modport is the requesting side; the slave modport is the memory side.
interface frv_dmem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            wen;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            recv;
    logic            ack;
    logic [XLEN-1:0] rdata;
    logic            error;

    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, rdata, error
    );

    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, rdata, error
    );
endinterface

// File: rtl/frv_dmem_arbiter.sv
// Round-robin two-master arbiter for the core data-memory port, with an in-order owner FIFO
// steering responses back. Optional drain fence enabled by FRV_DARB_FENCE_EN.
module frv_dmem_arbiter #(
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 2
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    frv_dmem_arbiter_if.slave  m0,
    frv_dmem_arbiter_if.slave  m1,
    frv_dmem_arbiter_if.master s,
`ifdef FRV_DARB_FENCE_EN
    input  logic               fence_req,
    output logic               fence_done,
`endif
    output logic               arb_busy
);

    localparam int PW = 2;
    localparam int CW = 3;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_HOLD  = 2'd1
`ifdef FRV_DARB_FENCE_EN
        , ST_DRAIN = 2'd2
`endif
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            sel_r;
    logic            sel_s;
    logic            issue_s;
    logic            last_gnt_r;
    logic [CW-1:0]   count_r;
    logic [3:0]      owner_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic            full_s;
    logic            empty_s;
    logic            fence_now_s;
    logic            fence_done_s;
    logic            s_req_s;
    logic            grant_s;
    logic            head_s;
    logic            s_ack_s;
    logic            pop_s;
    logic            m0_recv_s;
    logic            m1_recv_s;

    assign full_s  = (count_r == MAX_CNT);
    assign empty_s = (count_r == 3'd0);

`ifdef FRV_DARB_FENCE_EN
    logic fence_pend_r;
    assign fence_now_s = fence_req;
`else
    assign fence_now_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: HOLD keeps an ungranted selection stable until the slave grants
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
`ifdef FRV_DARB_FENCE_EN
                if (fence_now_s) begin
                    state_nxt_s = ST_DRAIN;
                end else
`endif
                if (issue_s && !s.gnt) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_HOLD: begin
                if (grant_s) begin
`ifdef FRV_DARB_FENCE_EN
                    state_nxt_s = (fence_req || fence_pend_r) ? ST_DRAIN : ST_ARB;
`else
                    state_nxt_s = ST_ARB;
`endif
                end else if (!issue_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
`ifdef FRV_DARB_FENCE_EN
            ST_DRAIN: begin
                if (empty_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
`endif
            default: state_nxt_s = ST_ARB;
        endcase
    end

    // FSM outputs: master selection and whether a request is presented to the slave
    always_comb begin
        sel_s        = sel_r;
        issue_s      = 1'b0;
        fence_done_s = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (full_s || fence_now_s) begin
                    sel_s   = 1'b0;
                    issue_s = 1'b0;
                end else if (m0.req && m1.req) begin
                    sel_s   = ~last_gnt_r;
                    issue_s = 1'b1;
                end else if (m1.req) begin
                    sel_s   = 1'b1;
                    issue_s = 1'b1;
                end else if (m0.req) begin
                    sel_s   = 1'b0;
                    issue_s = 1'b1;
                end else begin
                    sel_s   = 1'b0;
                    issue_s = 1'b0;
                end
            end
            ST_HOLD: begin
                sel_s   = sel_r;
                issue_s = sel_r ? m1.req : m0.req;
            end
`ifdef FRV_DARB_FENCE_EN
            ST_DRAIN: begin
                sel_s        = sel_r;
                issue_s      = 1'b0;
                fence_done_s = empty_s;
            end
`endif
            default: begin
                sel_s   = 1'b0;
                issue_s = 1'b0;
            end
        endcase
    end

    assign s_req_s = g_resetn && issue_s;
    assign grant_s = s_req_s && s.gnt;

    // Response steering: the FIFO head names the master owning the oldest outstanding request
    assign head_s    = owner_r[rd_ptr_r];
    assign s_ack_s   = g_resetn && !empty_s && (head_s ? m1.ack : m0.ack);
    assign pop_s     = s.recv && s_ack_s;
    assign m0_recv_s = g_resetn && s.recv && !empty_s && !head_s;
    assign m1_recv_s = g_resetn && s.recv && !empty_s && head_s;

    // Selection, round-robin history, outstanding count and owner FIFO
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            sel_r      <= 1'b0;
            last_gnt_r <= 1'b1;
            count_r    <= 3'd0;
            owner_r    <= 4'd0;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
        end else begin
            sel_r   <= sel_s;
            count_r <= count_r + {2'b00, grant_s} - {2'b00, pop_s};
            if (grant_s) begin
                last_gnt_r        <= sel_s;
                owner_r[wr_ptr_r] <= sel_s;
                wr_ptr_r          <= (wr_ptr_r == PTR_LAST) ? 2'd0 : wr_ptr_r + 2'd1;
            end else if (fence_done_s) begin
                last_gnt_r <= 1'b1;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? 2'd0 : rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

`ifdef FRV_DARB_FENCE_EN
    // Remembers a fence raised while a held request still waits for its grant
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            fence_pend_r <= 1'b0;
        end else if (state_r == ST_HOLD && state_nxt_s != ST_HOLD) begin
            fence_pend_r <= 1'b0;
        end else if (state_r == ST_HOLD && fence_req) begin
            fence_pend_r <= 1'b1;
        end else begin
            fence_pend_r <= fence_pend_r;
        end
    end

    assign fence_done = g_resetn && fence_done_s;
`endif

    assign s.req   = s_req_s;
    assign s.wen   = g_resetn && (sel_s ? m1.wen : m0.wen);
    assign s.strb  = g_resetn ? (sel_s ? m1.strb  : m0.strb)  : 4'b0000;
    assign s.wdata = g_resetn ? (sel_s ? m1.wdata : m0.wdata) : {XLEN{1'b0}};
    assign s.addr  = g_resetn ? (sel_s ? m1.addr  : m0.addr)  : {XLEN{1'b0}};
    assign s.ack   = s_ack_s;

    assign m0.gnt   = grant_s && !sel_s;
    assign m1.gnt   = grant_s && sel_s;
    assign m0.recv  = m0_recv_s;
    assign m1.recv  = m1_recv_s;
    assign m0.rdata = m0_recv_s ? s.rdata : {XLEN{1'b0}};
    assign m1.rdata = m1_recv_s ? s.rdata : {XLEN{1'b0}};
    assign m0.error = m0_recv_s && s.error;
    assign m1.error = m1_recv_s && s.error;

    assign arb_busy = g_resetn && ((state_r == ST_HOLD) || !empty_s);

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Self-checking bench for frv_dmem_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based reference model.
module tb_frv_dmem_arbiter;
    localparam int XLEN = 32;
    localparam int MAXO = 2;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic arb_busy;
`ifdef FRV_DARB_FENCE_EN
    logic fence_req = 1'b0;
    logic fence_done;
`endif

    always #5 g_clk = ~g_clk;

    frv_dmem_arbiter_if #(.XLEN(XLEN)) m0 ();
    frv_dmem_arbiter_if #(.XLEN(XLEN)) m1 ();
    frv_dmem_arbiter_if #(.XLEN(XLEN)) s ();

    frv_dmem_arbiter #(.XLEN(XLEN), .MAX_OUT(MAXO)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .m0        (m0),
        .m1        (m1),
        .s         (s),
`ifdef FRV_DARB_FENCE_EN
        .fence_req (fence_req),
        .fence_done(fence_done),
`endif
        .arb_busy  (arb_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owners of outstanding requests in issue order, last winner,
    // master whose request waits for a grant (-1 none), drain mode.
    int q[$];
    int last_w = 1;
    int held   = -1;
    bit drain  = 1'b0;
    bit pend   = 1'b0;
    bit eg0, eg1;
    bit act[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_w = 1;
        held   = -1;
        drain  = 1'b0;
        pend   = 1'b0;
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic tick();
        int sel;
        int hd;
        bit sreq, eack, er0, er1, pop, fin, edone, was_drain;
        bit in_rst;
        sel = 0; sreq = 1'b0; fin = 1'b0; edone = 1'b0;
        eg0 = 1'b0; eg1 = 1'b0;
`ifdef FRV_DARB_FENCE_EN
        fin = fence_req;
`endif
        #1;
        in_rst = !g_resetn;
        if (in_rst) begin
            chk("rst_sreq", s.req, 0);
            chk("rst_gnt", {m0.gnt, m1.gnt}, 0);
            chk("rst_recv", {m0.recv, m1.recv}, 0);
            chk("rst_sack", s.ack, 0);
            chk("rst_addr", s.addr, 0);
            chk("rst_busy", arb_busy, 0);
`ifdef FRV_DARB_FENCE_EN
            chk("rst_fdone", fence_done, 0);
`endif
        end else begin
            if (drain) begin
                sreq = 1'b0;
            end else if (held >= 0) begin
                sel  = held;
                sreq = (held == 0) ? m0.req : m1.req;
                chk("proto_hold_req", {63'd0, sreq}, 1);
            end else if (q.size() == MAXO || fin) begin
                sreq = 1'b0;
            end else if (m0.req && m1.req) begin
                sel = 1 - last_w; sreq = 1'b1;
            end else if (m0.req) begin
                sel = 0; sreq = 1'b1;
            end else if (m1.req) begin
                sel = 1; sreq = 1'b1;
            end
            eg0  = sreq && s.gnt && sel == 0;
            eg1  = sreq && s.gnt && sel == 1;
            hd   = (q.size() != 0) ? q[0] : -1;
            er0  = s.recv && hd == 0;
            er1  = s.recv && hd == 1;
            eack = (hd == 0 && m0.ack) || (hd == 1 && m1.ack);
            edone = drain && q.size() == 0;
            chk("sreq", s.req, sreq);
            chk("m0_gnt", m0.gnt, eg0);
            chk("m1_gnt", m1.gnt, eg1);
            chk("m0_recv", m0.recv, er0);
            chk("m1_recv", m1.recv, er1);
            chk("s_ack", s.ack, eack);
            chk("busy", arb_busy, (held >= 0) || q.size() != 0);
            chk("m0_rdata", m0.rdata, er0 ? s.rdata : 32'd0);
            chk("m1_rdata", m1.rdata, er1 ? s.rdata : 32'd0);
            chk("m0_err", m0.error, er0 && s.error);
            chk("m1_err", m1.error, er1 && s.error);
            if (sreq) begin
                chk("s_addr", s.addr, sel ? m1.addr : m0.addr);
                chk("s_wdata", s.wdata, sel ? m1.wdata : m0.wdata);
                chk("s_strb", s.strb, sel ? m1.strb : m0.strb);
                chk("s_wen", s.wen, sel ? m1.wen : m0.wen);
            end
`ifdef FRV_DARB_FENCE_EN
            chk("fence_done", fence_done, edone);
`endif
        end
        pop = s.recv && eack;
        @(posedge g_clk);
        if (in_rst) begin
            model_reset();
        end else begin
            was_drain = drain;
            if (pop) void'(q.pop_front());
            if (eg0 || eg1) begin
                last_w = sel;
                q.push_back(sel);
                if (held >= 0 && (fin || pend)) drain = 1'b1;
                held = -1;
                pend = 1'b0;
            end else if (held >= 0) begin
                if (!sreq) begin
                    held = -1;
                    pend = 1'b0;
                end else if (fin) begin
                    pend = 1'b1;
                end
            end else if (!was_drain && fin) begin
                drain = 1'b1;
            end else if (!was_drain && sreq) begin
                held = sel;
            end
            if (edone) begin
                drain  = 1'b0;
                last_w = 1;
            end
        end
        @(negedge g_clk);
    endtask

    task automatic idle_inputs();
        m0.req = 1'b0; m0.wen = 1'b0; m0.strb = 4'h0; m0.wdata = 32'd0; m0.addr = 32'd0; m0.ack = 1'b0;
        m1.req = 1'b0; m1.wen = 1'b0; m1.strb = 4'h0; m1.wdata = 32'd0; m1.addr = 32'd0; m1.ack = 1'b0;
        s.gnt = 1'b0; s.recv = 1'b0; s.rdata = 32'd0; s.error = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge g_clk);
        // reset with live inputs must still hold every output low
        m0.req = 1'b1; s.gnt = 1'b1; s.recv = 1'b1; m0.ack = 1'b1;
        tick();
        tick();
        idle_inputs();
        g_resetn = 1'b1;
        #1 chk("post_rst_busy", arb_busy, 0);
        tick();

        // both request continuously: m0 wins the first tie, then alternation, then saturation
        m0.req = 1'b1; m0.addr = 32'h100; m1.req = 1'b1; m1.addr = 32'h200; s.gnt = 1'b1;
        #1 chk("A_first_m0", {m0.gnt, m1.gnt}, 2'b10);
        tick();
        #1 chk("A_second_m1", {m0.gnt, m1.gnt}, 2'b01);
        tick();
        #1 chk("A_saturated", s.req, 0);
        tick();
        m0.req = 1'b0; m1.req = 1'b0; s.gnt = 1'b0;

        // responses routed in order; m0 stalls its ack for two cycles
        s.recv = 1'b1; s.rdata = 32'hAAAA0000; m0.ack = 1'b0;
        #1 chk("C_m0_data", m0.rdata, 32'hAAAA0000);
        chk("C_stall_ack", s.ack, 0);
        tick();
        tick();
        m0.ack = 1'b1;
        #1 chk("C_ack", s.ack, 1);
        tick();
        m0.ack = 1'b0; m1.ack = 1'b1; s.rdata = 32'h5555FFFF; s.error = 1'b1;
        #1 chk("C_m1_data", m1.rdata, 32'h5555FFFF);
        chk("C_m1_err", {m1.recv, m1.error, m0.recv}, 3'b110);
        tick();
        s.recv = 1'b0; s.error = 1'b0; m1.ack = 1'b0;
        #1 chk("C_idle", arb_busy, 0);
        tick();

        // m1 write held for three cycles while m0 starts requesting
        m1.req = 1'b1; m1.wen = 1'b1; m1.addr = 32'h1004; m1.strb = 4'b1100; m1.wdata = 32'hCAFE0001;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m0.req = 1'b1; m0.addr = 32'h2000;
            end
            #1 chk("B_addr", s.addr, 32'h1004);
            chk("B_strb", s.strb, 4'b1100);
            tick();
        end
        s.gnt = 1'b1;
        #1 chk("B_gnt_m1", {m0.gnt, m1.gnt}, 2'b01);
        tick();
        m1.req = 1'b0; m1.wen = 1'b0;
        #1 chk("B_gnt_m0", {m0.gnt, m1.gnt}, 2'b10);
        tick();
        m0.req = 1'b0; s.gnt = 1'b0;
        s.recv = 1'b1; m0.ack = 1'b1; m1.ack = 1'b1; s.rdata = 32'h0BADF00D;
        #1 chk("B_rsp_m1_first", {m0.recv, m1.recv}, 2'b01);
        tick();
        tick();
        s.recv = 1'b0; m0.ack = 1'b0; m1.ack = 1'b0;

        // one outstanding, new grant and pop in the same cycle
        m0.req = 1'b1; s.gnt = 1'b1;
        tick();
        m0.req = 1'b0; m1.req = 1'b1; s.recv = 1'b1; s.rdata = 32'h12345678; m0.ack = 1'b1;
        #1 chk("D_pop_and_gnt", {m0.recv, m1.gnt}, 2'b11);
        tick();
        m1.req = 1'b0; s.recv = 1'b0; m0.ack = 1'b0;
        #1 chk("D_busy", arb_busy, 1);
        tick();
        s.recv = 1'b1; m1.ack = 1'b1; s.rdata = 32'h00000009;
        #1 chk("D_m1_recv", {m0.recv, m1.recv}, 2'b01);
        tick();
        s.recv = 1'b0; m1.ack = 1'b0;

        // reset while a request is held with one outstanding; stray response afterwards
        m0.req = 1'b1;
        tick();
        m0.req = 1'b0; s.gnt = 1'b0; m1.req = 1'b1; m1.addr = 32'h3000;
        tick();
        #1 chk("E_busy_hold", arb_busy, 1);
        g_resetn = 1'b0;
        tick();
        idle_inputs();
        g_resetn = 1'b1;
        s.recv = 1'b1; m0.ack = 1'b1; m1.ack = 1'b1;
        #1 chk("E_stray_ack", s.ack, 0);
        chk("E_busy", arb_busy, 0);
        tick();
        idle_inputs();

        // randomized traffic; a master keeps its request and fields until granted
        act[0] = 1'b0; act[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(0, 2) == 0) begin
                    act[n] = 1'b1;
                    if (n == 0) begin
                        m0.addr = $urandom; m0.wdata = $urandom; m0.wen = 1'($urandom_range(0, 1));
                        m0.strb = 4'($urandom_range(0, 15));
                    end else begin
                        m1.addr = $urandom; m1.wdata = $urandom; m1.wen = 1'($urandom_range(0, 1));
                        m1.strb = 4'($urandom_range(0, 15));
                    end
                end
            end
            m0.req  = act[0];
            m1.req  = act[1];
            s.gnt   = ($urandom_range(0, 3) != 0);
            s.recv  = 1'($urandom_range(0, 1));
            s.rdata = $urandom;
            s.error = ($urandom_range(0, 7) == 0);
            m0.ack  = ($urandom_range(0, 3) != 0);
            m1.ack  = ($urandom_range(0, 3) != 0);
`ifdef FRV_DARB_FENCE_EN
            fence_req = ($urandom_range(0, 31) == 0);
`endif
            tick();
            if (eg0) act[0] = 1'b0;
            if (eg1) act[1] = 1'b0;
        end

        // let pending requests finish, then drain all responses
`ifdef FRV_DARB_FENCE_EN
        fence_req = 1'b0;
`endif
        s.gnt = 1'b1; s.recv = 1'b1; m0.ack = 1'b1; m1.ack = 1'b1;
        for (int i = 0; i < 40 && (act[0] || act[1]); i++) begin
            m0.req = act[0];
            m1.req = act[1];
            tick();
            if (eg0) act[0] = 1'b0;
            if (eg1) act[1] = 1'b0;
        end
        chk("R_pending_granted", {act[0], act[1]}, 0);
        m0.req = 1'b0; m1.req = 1'b0; s.gnt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1 chk("R_drained", arb_busy, 0);
        idle_inputs();
        tick();

`ifdef FRV_DARB_FENCE_EN
        // fence with two outstanding: no issue, done pulse once drained, next tie to m0
        m0.req = 1'b1; m1.req = 1'b1; s.gnt = 1'b1;
        tick();
        tick();
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        s.recv = 1'b1; m0.ack = 1'b1; m1.ack = 1'b1;
        #1 chk("F_no_gnt", {m0.gnt, m1.gnt}, 2'b00);
        tick();
        tick();
        s.recv = 1'b0;
        #1 chk("F_done", fence_done, 1);
        chk("F_no_gnt2", {m0.gnt, m1.gnt}, 2'b00);
        tick();
        #1 chk("F_done_once", fence_done, 0);
        chk("F_tie_m0", {m0.gnt, m1.gnt}, 2'b10);
        tick();
        idle_inputs();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
